// File: rtl/apb_master_bridge.sv
// APB master bridge: turns level-valid requests into APB SETUP/ACCESS cycles toward two slaves (optional APB_TIMEOUT_EN).
// Latency: request edge to completion edge is 2 cycles, plus 1 per PREADY wait state.
// Backpressure: PREADY low holds ACCESS; requests are sampled only in IDLE and on the completing edge.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH:0]   apb_write_paddr,
  input  logic [ADDR_WIDTH:0]   apb_read_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  output logic [DATA_WIDTH-1:0] apb_read_data_out,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR_IN
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH:0]   addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state, state_nxt;
  req_t                  req;
  logic                  complete;
  logic                  load_req;
  logic                  timeout_hit;

  logic                  psel1_d, psel2_d, penable_d, pwrite_d, pslverr_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d, rdata_d;

  always_comb begin
    req.write = READ_WRITE;
    req.addr  = READ_WRITE ? apb_write_paddr : apb_read_paddr;
    req.wdata = apb_write_data;
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt equals the number of stalled ACCESS cycles already seen, so the
  // limit is reached on the TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!PREADY) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  assign complete = (state == ACCESS) && (PREADY || timeout_hit);
  assign load_req = transfer && ((state == IDLE) || complete);

  // State and registered APB outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state             <= IDLE;
      PSEL1             <= 1'b0;
      PSEL2             <= 1'b0;
      PENABLE           <= 1'b0;
      PWRITE            <= 1'b0;
      PADDR             <= '0;
      PWDATA            <= '0;
      apb_read_data_out <= '0;
      PSLVERR           <= 1'b0;
    end else begin
      state             <= state_nxt;
      PSEL1             <= psel1_d;
      PSEL2             <= psel2_d;
      PENABLE           <= penable_d;
      PWRITE            <= pwrite_d;
      PADDR             <= paddr_d;
      PWDATA            <= pwdata_d;
      apb_read_data_out <= rdata_d;
      PSLVERR           <= pslverr_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = transfer ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = transfer ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel1_d   = PSEL1;
    psel2_d   = PSEL2;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    rdata_d   = apb_read_data_out;
    pslverr_d = PSLVERR;

    // A forced completion reports an error and returns zero read data.
    if (complete) begin
      pslverr_d = timeout_hit ? 1'b1 : PSLVERR_IN;
      if (!PWRITE) begin
        rdata_d = timeout_hit ? '0 : PRDATA;
      end
    end

    if (load_req) begin
      psel1_d   = !req.addr[ADDR_WIDTH];
      psel2_d   = req.addr[ADDR_WIDTH];
      penable_d = 1'b0;
      pwrite_d  = req.write;
      paddr_d   = req.addr[ADDR_WIDTH-1:0];
      if (req.write) begin
        pwdata_d = req.wdata;
      end
    end else begin
      case (state)
        SETUP: penable_d = 1'b1;
        ACCESS: begin
          if (complete) begin
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
          end
        end
        default: begin
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: scenario tasks plus a completion scoreboard.
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          transfer = 1'b0;
  logic          READ_WRITE = 1'b0;
  logic [AW:0]   apb_write_paddr = '0;
  logic [AW:0]   apb_read_paddr = '0;
  logic [DW-1:0] apb_write_data = '0;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR_IN = 1'b0;

  logic [DW-1:0] apb_read_data_out;
  logic          PSLVERR;
  logic [AW-1:0] PADDR;
  logic          PSEL1, PSEL2, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] model_rd = '0;
  logic          prev_pen = 1'b0;
  int            checks = 0;
  int            passes = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .transfer(transfer),
    .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr),
    .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data),
    .apb_read_data_out(apb_read_data_out),
    .PSLVERR(PSLVERR),
    .PADDR(PADDR),
    .PSEL1(PSEL1),
    .PSEL2(PSEL2),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR_IN(PSLVERR_IN)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // A completion is an ACCESS cycle followed by PENABLE low.
  always @(negedge PCLK) begin
    if (PRESET) begin
      prev_pen = 1'b0;
    end else begin
      if (prev_pen && !PENABLE) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: completion seen with no expected transfer");
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if (apb_read_data_out !== mon_e.rd)
            $display("FAIL sb_rdata: got %h want %h", apb_read_data_out, mon_e.rd);
          else passes++;
          checks++;
          if (PSLVERR !== mon_e.err)
            $display("FAIL sb_pslverr: got %b want %b", PSLVERR, mon_e.err);
          else passes++;
        end
      end
      prev_pen = PENABLE;
    end
  end

  task automatic push_exp(input logic wr, input logic [DW-1:0] rd, input logic err);
    exp_t e;
    if (!wr) model_rd = rd;
    e.rd  = model_rd;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic start_req(input logic wr, input logic [AW:0] addr, input logic [DW-1:0] wd);
    transfer   = 1'b1;
    READ_WRITE = wr;
    if (wr) begin
      apb_write_paddr = addr;
      apb_read_paddr  = ~addr;
    end else begin
      apb_read_paddr  = addr;
      apb_write_paddr = ~addr;
    end
    apb_write_data = wd;
  endtask

  task automatic test_reset;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE, PSLVERR} !== 5'b0)
      $display("FAIL rst_ctrl: got %b want 00000", {PSEL1, PSEL2, PENABLE, PWRITE, PSLVERR}); else passes++;
    checks++; if (PADDR !== 8'h00) $display("FAIL rst_paddr: got %h want 00", PADDR); else passes++;
    checks++; if (PWDATA !== 8'h00) $display("FAIL rst_pwdata: got %h want 00", PWDATA); else passes++;
    checks++; if (apb_read_data_out !== 8'h00) $display("FAIL rst_rdata: got %h want 00", apb_read_data_out); else passes++;
    PRESET = 1'b0;
    PREADY = 1'b1;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b000)
      $display("FAIL rst_idle: got %b want 000", {PSEL1, PSEL2, PENABLE}); else passes++;
  endtask

  task automatic test_single_write;
    start_req(1'b1, 9'h012, 8'hA5);
    PREADY = 1'b1; PSLVERR_IN = 1'b0;
    push_exp(1'b1, 8'h00, 1'b0);
    @(negedge PCLK);
    transfer = 1'b0;
    apb_write_data = 8'hFF;
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1001)
      $display("FAIL wr_setup_ctrl: got %b want 1001", {PSEL1, PSEL2, PENABLE, PWRITE}); else passes++;
    checks++; if (PADDR !== 8'h12) $display("FAIL wr_paddr: got %h want 12", PADDR); else passes++;
    checks++; if (PWDATA !== 8'hA5) $display("FAIL wr_pwdata: got %h want a5", PWDATA); else passes++;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1011)
      $display("FAIL wr_access_ctrl: got %b want 1011", {PSEL1, PSEL2, PENABLE, PWRITE}); else passes++;
    checks++; if (PWDATA !== 8'hA5) $display("FAIL wr_pwdata_stable: got %h want a5", PWDATA); else passes++;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b000)
      $display("FAIL wr_idle: got %b want 000", {PSEL1, PSEL2, PENABLE}); else passes++;
    checks++; if (PSLVERR !== 1'b0) $display("FAIL wr_pslverr: got %b want 0", PSLVERR); else passes++;
  endtask

  task automatic test_read_wait;
    int pen;
    start_req(1'b0, 9'h1F0, 8'h77);
    PREADY = 1'b0;
    push_exp(1'b0, 8'h3C, 1'b0);
    @(negedge PCLK);
    transfer = 1'b0;
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0100)
      $display("FAIL rd_setup_ctrl: got %b want 0100", {PSEL1, PSEL2, PENABLE, PWRITE}); else passes++;
    checks++; if (PADDR !== 8'hF0) $display("FAIL rd_paddr: got %h want f0", PADDR); else passes++;
    checks++; if (PWDATA !== 8'hA5) $display("FAIL rd_pwdata_hold: got %h want a5", PWDATA); else passes++;
    pen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      if (!PENABLE) break;
      pen++;
      PREADY = (pen == 4);
      PRDATA = (pen == 4) ? 8'h3C : 8'hEE;
    end
    checks++; if (pen != 4) $display("FAIL rd_wait_cycles: got %0d want 4", pen); else passes++;
    checks++; if (apb_read_data_out !== 8'h3C) $display("FAIL rd_data: got %h want 3c", apb_read_data_out); else passes++;
    PREADY = 1'b1;
  endtask

  task automatic test_back_to_back;
    start_req(1'b1, 9'h005, 8'h11);
    PREADY = 1'b1;
    push_exp(1'b1, 8'h00, 1'b0);
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1001)
      $display("FAIL b2b_wr_setup: got %b want 1001", {PSEL1, PSEL2, PENABLE, PWRITE}); else passes++;
    start_req(1'b0, 9'h105, 8'h22);
    PRDATA = 8'h5A;
    push_exp(1'b0, 8'h5A, 1'b0);
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1011)
      $display("FAIL b2b_wr_access: got %b want 1011", {PSEL1, PSEL2, PENABLE, PWRITE}); else passes++;
    checks++; if (PADDR !== 8'h05) $display("FAIL b2b_wr_paddr: got %h want 05", PADDR); else passes++;
    @(negedge PCLK);
    transfer = 1'b0;
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0100)
      $display("FAIL b2b_rd_setup: got %b want 0100", {PSEL1, PSEL2, PENABLE, PWRITE}); else passes++;
    checks++; if (PWDATA !== 8'h11) $display("FAIL b2b_pwdata_hold: got %h want 11", PWDATA); else passes++;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b011)
      $display("FAIL b2b_rd_access: got %b want 011", {PSEL1, PSEL2, PENABLE}); else passes++;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b000)
      $display("FAIL b2b_idle: got %b want 000", {PSEL1, PSEL2, PENABLE}); else passes++;
    checks++; if (apb_read_data_out !== 8'h5A) $display("FAIL b2b_rdata: got %h want 5a", apb_read_data_out); else passes++;
  endtask

  task automatic test_slave_error;
    start_req(1'b0, 9'h033, 8'h00);
    PRDATA = 8'hC7; PSLVERR_IN = 1'b1; PREADY = 1'b1;
    push_exp(1'b0, 8'hC7, 1'b1);
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if (PSLVERR !== 1'b1) $display("FAIL err_pslverr: got %b want 1", PSLVERR); else passes++;
    checks++; if (apb_read_data_out !== 8'hC7) $display("FAIL err_rdata: got %h want c7", apb_read_data_out); else passes++;
    start_req(1'b1, 9'h044, 8'h99);
    PSLVERR_IN = 1'b0; PRDATA = 8'h00;
    push_exp(1'b1, 8'h00, 1'b0);
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if (PSLVERR !== 1'b0) $display("FAIL err_clear: got %b want 0", PSLVERR); else passes++;
    checks++; if (apb_read_data_out !== 8'hC7) $display("FAIL err_wr_rdata_hold: got %h want c7", apb_read_data_out); else passes++;
  endtask

  task automatic test_timeout;
    int pen;
    start_req(1'b0, 9'h0CC, 8'h00);
    PREADY = 1'b0; PRDATA = 8'hEE; PSLVERR_IN = 1'b0;
`ifdef APB_TIMEOUT_EN
    push_exp(1'b0, 8'h00, 1'b1);
    @(negedge PCLK); transfer = 1'b0;
    pen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (!PENABLE) break;
      pen++;
    end
    checks++; if (pen != TO) $display("FAIL to_cycles: got %0d want %0d", pen, TO); else passes++;
    checks++; if (PSLVERR !== 1'b1) $display("FAIL to_pslverr: got %b want 1", PSLVERR); else passes++;
    checks++; if (apb_read_data_out !== 8'h00) $display("FAIL to_rdata: got %h want 00", apb_read_data_out); else passes++;
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b000)
      $display("FAIL to_idle: got %b want 000", {PSEL1, PSEL2, PENABLE}); else passes++;
`else
    push_exp(1'b0, 8'hEE, 1'b0);
    @(negedge PCLK); transfer = 1'b0;
    pen = 0;
    repeat (30) @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b101)
      $display("FAIL stall_hold: got %b want 101", {PSEL1, PSEL2, PENABLE}); else passes++;
    PREADY = 1'b1;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b000)
      $display("FAIL stall_idle: got %b want 000", {PSEL1, PSEL2, PENABLE}); else passes++;
    checks++; if (apb_read_data_out !== 8'hEE) $display("FAIL stall_rdata: got %h want ee", apb_read_data_out); else passes++;
    checks++; if (pen != 0) $display("FAIL stall_counter: got %0d want 0", pen); else passes++;
`endif
    PREADY = 1'b1;
  endtask

  task automatic test_reset_mid_access;
    start_req(1'b1, 9'h0AB, 8'h3E);
    PSLVERR_IN = 1'b1; PREADY = 1'b1;
    push_exp(1'b1, 8'h00, 1'b1);
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if (PSLVERR !== 1'b1) $display("FAIL rma_pre_err: got %b want 1", PSLVERR); else passes++;
    start_req(1'b0, 9'h1CD, 8'h00);
    PREADY = 1'b0; PSLVERR_IN = 1'b0;
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
    checks++; if ({PSEL2, PENABLE} !== 2'b11) $display("FAIL rma_in_access: got %b want 11", {PSEL2, PENABLE}); else passes++;
    #2 PRESET = 1'b1;
    #1;
    checks++; if ({PSEL1, PSEL2, PENABLE, PWRITE, PSLVERR} !== 5'b0)
      $display("FAIL rma_ctrl: got %b want 00000", {PSEL1, PSEL2, PENABLE, PWRITE, PSLVERR}); else passes++;
    checks++; if (PADDR !== 8'h00) $display("FAIL rma_paddr: got %h want 00", PADDR); else passes++;
    checks++; if (PWDATA !== 8'h00) $display("FAIL rma_pwdata: got %h want 00", PWDATA); else passes++;
    checks++; if (apb_read_data_out !== 8'h00) $display("FAIL rma_rdata: got %h want 00", apb_read_data_out); else passes++;
    model_rd = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = 1'b1;
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, PENABLE} !== 3'b000)
      $display("FAIL rma_idle: got %b want 000", {PSEL1, PSEL2, PENABLE}); else passes++;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_wait;
    test_back_to_back;
    test_slave_error;
    test_timeout;
    test_reset_mid_access;
    checks++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB master that turns the request-level interface driven by the bench (transfer, READ_WRITE, write/read addresses, write data) into APB protocol cycles toward two slaves.
- Returns read data and slave error status on apb_read_data_out / PSLVERR.
- Sits directly downstream of the APB driver interface and upstream of the APB slaves.
- The MSB of the request address selects the slave; the remaining bits form PADDR.

Parameters:
- ADDR_WIDTH, 8, PADDR width; request addresses are ADDR_WIDTH+1 bits (MSB = slave select).
- DATA_WIDTH, 8, data width for PWDATA, PRDATA and apb_read_data_out.
- TIMEOUT_CYCLES, 16, ACCESS wait-state limit (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  input  1  clock; all state changes on rising edge.
- PRESET  input  1  reset, asynchronous, active-high.
- transfer  input  1  request valid, level-sensitive.
- READ_WRITE  input  1  0 = read, 1 = write.
- apb_write_paddr  input  ADDR_WIDTH+1  write address; MSB selects slave.
- apb_read_paddr  input  ADDR_WIDTH+1  read address; MSB selects slave.
- apb_write_data  input  DATA_WIDTH  write data.
- apb_read_data_out  output  DATA_WIDTH  data of the last completed read.
- PSLVERR  output  1  error status of the last completed transfer.
- PADDR  output  ADDR_WIDTH  APB address.
- PSEL1  output  1  select for slave 0 (address MSB = 0).
- PSEL2  output  1  select for slave 1 (address MSB = 1).
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  read data from the selected slave (already muxed).
- PREADY  input  1  ready from the selected slave.
- PSLVERR_IN  input  1  error from the selected slave.

Behaviour:
- Reset: PRESET=1 asynchronously forces IDLE and clears all outputs (PSEL1/PSEL2/PENABLE/PWRITE=0, PADDR/PWDATA/apb_read_data_out=0, PSLVERR=0). This includes reset mid-SETUP or mid-ACCESS; the in-flight transfer is dropped with no completion effects.
- FSM has three states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - PSEL*=0, PENABLE=0.
  - transfer=1 at an edge → SETUP next cycle.
  - On that edge, latch PWRITE=READ_WRITE; address = READ_WRITE ? apb_write_paddr : apb_read_paddr; PWDATA=apb_write_data when writing, else PWDATA holds its previous value.
- SETUP:
  - PSEL1 or PSEL2 high per latched address MSB (exactly one), PENABLE=0. Latched address bits [ADDR_WIDTH-1:0] appear on PADDR.
  - Always → ACCESS after 1 cycle; transfer is ignored.
- ACCESS:
  - PSEL held, PENABLE=1; PADDR/PWRITE/PWDATA stable.
  - PREADY=0: stay in ACCESS (wait state), unlimited.
  - PREADY=1: transfer completes on that edge.
    - Read: apb_read_data_out ← PRDATA. Write: apb_read_data_out unchanged.
    - PSLVERR ← PSLVERR_IN (for both reads and writes).
    - If transfer=1 on the same edge → SETUP, latching the new request (back-to-back, no IDLE cycle). PENABLE drops; PSEL follows the new address MSB.
    - Else → IDLE.
- apb_read_data_out and PSLVERR hold their values until the next completion.
- Minimum latency: request edge to completion edge = 2 cycles (SETUP + 1 ACCESS); each wait state adds 1.
- Request inputs are sampled only in IDLE and at ACCESS completion. Changes at other times have no effect.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - If PREADY is still 0 on the TIMEOUT_CYCLES-th ACCESS cycle, the transfer is force-completed on that edge: PSLVERR←1; for a read, apb_read_data_out←0.
  - Next-state rules are identical to a normal completion.
- When not defined: no counter exists and ACCESS waits on PREADY indefinitely.

Test Plan:
- Reset mid-ACCESS: assert PRESET while PENABLE=1 → all outputs 0 immediately, without waiting for a clock edge; FSM in IDLE after release.
- Single write, no wait: transfer=1, READ_WRITE=1, apb_write_paddr=9'h012, apb_write_data=8'hA5, PREADY=1 → SETUP cycle with PSEL1=1, PADDR=8'h12, PWDATA=8'hA5, PWRITE=1; next cycle PENABLE=1; PSLVERR=0 after completion; IDLE afterwards.
- Read from slave 1 with 3 wait states: apb_read_paddr=9'h1F0, PRDATA=8'h3C, PREADY low 3 cycles → PSEL2=1, PADDR=8'hF0, PENABLE high for 4 cycles; apb_read_data_out=8'h3C after completion.
- Back-to-back: write 9'h005/8'h11 then read 9'h105 with transfer held high → ACCESS goes directly to SETUP; PSEL1 switches to PSEL2 with no IDLE cycle; PENABLE low exactly 1 cycle between transfers.
- Slave error: read with PSLVERR_IN=1 and PREADY=1 → PSLVERR=1 and apb_read_data_out=PRDATA; a following clean write → PSLVERR returns to 0.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 → forced completion on the 16th ACCESS cycle; PSLVERR=1, apb_read_data_out=0, FSM returns to IDLE.
